crossing_interval_averager: RTL and testbench
=============================================

Name: crossing_interval_averager

Overview:
- Sits directly downstream of the zero-crossing detector (DS generator).
- Consumes that stage's crossing pulse and inter-crossing sample count.
- Rejects out-of-range intervals and averages 2^LOG2_N valid intervals.
- Presents the averaged half-period and full period over a valid/ready interface, and raises a frequency-lock flag when successive averages agree.

Parameters:
- DW, 8: width of the incoming interval count and of the averaged half-period.
- LOG2_N, 2: log2 of intervals per averaging window; legal range 1..6.
- MIN_D, 2: smallest accepted interval (inclusive).
- MAX_D, 250: largest accepted interval (inclusive).
- LOCK_TOL, 2: maximum absolute difference between consecutive averages that counts as a match.
- LOCK_CNT, 3: consecutive matches required to assert locked.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_pulse  in  1  single-cycle crossing strobe from the upstream detector.
- d_count  in  DW  interval count; sampled only in cycles where s_pulse=1.
- avg_valid  out  1  averaged result available.
- avg_ready  in  1  consumer accepts the result.
- avg_half  out  DW  averaged half-period, in samples.
- avg_period  out  DW+1  averaged full period, in samples.
- locked  out  1  frequency stable.
- reject_cnt  out  8  count of rejected intervals; saturates at 255.
- overrun  out  1  sticky flag: an unconsumed result was overwritten.

Behaviour:
- Reset (async, any state) clears everything:
  - all outputs to 0;
  - accumulator and window counter to 0;
  - lock match counter to 0;
  - "previous average present" flag to 0;
  - FSM to SKIP.
- Control FSM:
  - SKIP: the first s_pulse after reset is discarded (partial interval) and moves the FSM to RUN. No accumulate, no reject count.
  - RUN: every s_pulse is qualified. RUN has no exit other than reset.
- Qualification:
  - MIN_D <= d_count <= MAX_D: accept. acc += d_count; window counter increments.
  - Otherwise: reject. reject_cnt increments (saturating); acc and window counter unchanged.
- Accumulator width is DW+LOG2_N; it cannot overflow.
- Window completion occurs on the accepted pulse that brings the count to 2^LOG2_N. On that clock edge:
  - acc and window counter clear to 0;
  - the full sum moves to the output stage, so results appear the cycle after the last accepted pulse.
- Result arithmetic on the window sum:
  - avg_half = sum >> LOG2_N, truncated toward zero.
  - avg_period = sum >> (LOG2_N-1), which keeps one extra bit of precision.
- Output handshake:
  - avg_valid rises together with the new avg_half/avg_period.
  - Result is held stable while avg_valid=1 and avg_ready=0.
  - A transfer occurs when avg_valid and avg_ready are both 1 at a clock edge; avg_valid then clears on that edge unless a new result loads on the same edge.
- Simultaneous transfer and completion: the new result loads, avg_valid stays 1, overrun is not set.
- Completion while avg_valid=1 and avg_ready=0: the new result overwrites the old one and overrun is set to 1. overrun clears only on reset.
- Accumulation continues regardless of the handshake; there is no back-pressure upstream.
- Lock tracking, evaluated at each completion:
  - No previous average: store it as the previous average; match counter stays 0.
  - Previous average present: if |new - prev| <= LOCK_TOL, the match counter increments, saturating at LOCK_CNT. Otherwise the match counter clears to 0.
  - The new average always replaces prev.
  - locked = (match counter == LOCK_CNT), registered; it updates in the same cycle avg_valid rises.
- s_pulse during reset is ignored.
- The window is not restarted by rejects; rejected intervals are simply excluded.

Test Plan:
- Constant interval, d_count=10 on 5 pulses spaced 10 cycles apart:
  - first pulse is skipped;
  - avg_valid rises the cycle after the 5th pulse with avg_half=10, avg_period=20;
  - reject_cnt=0.
- Jittered window: skip pulse, then 10, 11, 10, 11 (sum 42) -> avg_half=10, avg_period=21.
- Rejection: skip pulse, then 10, 1, 255, 10, 10, 10 -> reject_cnt=2; result arrives after the 6th qualified pulse with avg_half=10.
- Lock: 4 windows of constant 10 (avg_ready=1) -> locked stays 0 after windows 1–3 and is 1 after window 4.
  - A 5th window of constant 20 -> locked=0.
- Overrun: avg_ready=0 through two windows (avg 10, then avg 12) -> overrun=1; avg_half=12 with avg_valid=1.
  - Raise avg_ready for one cycle -> avg_valid=0; overrun stays 1.
- Reset mid-window: after 2 accepted pulses, assert reset -> all outputs 0 immediately.
  - After release, the first pulse is skipped again, and a full 4 accepted intervals are required before avg_valid.

Source files
------------

// File: rtl/crossing_interval_averager_if.sv
// Interval-in / average-out bundle for the crossing interval averager.
// master drives crossing strobes and ready; slave returns the averaged result.
interface crossing_interval_averager_if #(
    parameter int DW = 8
);
    logic          s_pulse;
    logic [DW-1:0] d_count;
    logic          avg_valid;
    logic          avg_ready;
    logic [DW-1:0] avg_half;
    logic [DW:0]   avg_period;
    logic          locked;
    logic [7:0]    reject_cnt;
    logic          overrun;

    modport master (
        output s_pulse, d_count, avg_ready,
        input  avg_valid, avg_half, avg_period, locked, reject_cnt, overrun
    );

    modport slave (
        input  s_pulse, d_count, avg_ready,
        output avg_valid, avg_half, avg_period, locked, reject_cnt, overrun
    );
endinterface

// File: rtl/crossing_interval_averager.sv
// Qualifies zero-crossing intervals, averages 2^LOG2_N accepted ones and
// publishes half-period / period with a lock flag over valid/ready.
module crossing_interval_averager #(
    parameter int DW       = 8,
    parameter int LOG2_N   = 2,
    parameter int MIN_D    = 2,
    parameter int MAX_D    = 250,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    crossing_interval_averager_if.slave   bus
);
    localparam int AW = DW + LOG2_N;
    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic {SKIP, RUN} state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic [LOG2_N-1:0] win_q;
    logic [DW-1:0]   prev_q;
    logic            prev_vld_q;
    logic [MW-1:0]   match_q;
    logic            avg_valid_q;
    logic [DW-1:0]   avg_half_q;
    logic [DW:0]     avg_period_q;
    logic            locked_q;
    logic [7:0]      reject_cnt_q;
    logic            overrun_q;

    logic            in_range;
    logic            accept;
    logic            reject;
    logic            complete;
    logic [AW-1:0]   sum_d;
    logic [DW-1:0]   half_d;
    logic [DW:0]     period_d;
    logic [DW-1:0]   diff;
    logic [MW-1:0]   match_d;

    always_comb begin
        in_range = (bus.d_count >= DW'(MIN_D)) && (bus.d_count <= DW'(MAX_D));
        accept   = (state_q == RUN) && bus.s_pulse && in_range;
        reject   = (state_q == RUN) && bus.s_pulse && !in_range;
        complete = accept && (win_q == '1);
        sum_d    = acc_q + AW'(bus.d_count);
        // Slicing the sum is the divide; the period keeps one more LSB.
        half_d   = sum_d[AW-1:LOG2_N];
        period_d = sum_d[AW-1:LOG2_N-1];
        diff     = (half_d >= prev_q) ? (half_d - prev_q) : (prev_q - half_d);
        match_d  = '0;
        if (prev_vld_q && (diff <= DW'(LOCK_TOL))) begin
            match_d = (match_q == MW'(LOCK_CNT)) ? match_q : match_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SKIP;
            acc_q        <= '0;
            win_q        <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            match_q      <= '0;
            avg_valid_q  <= 1'b0;
            avg_half_q   <= '0;
            avg_period_q <= '0;
            locked_q     <= 1'b0;
            reject_cnt_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // The first strobe after reset closes a partial interval; drop it.
            if (state_q == SKIP && bus.s_pulse) begin
                state_q <= RUN;
            end

            if (accept) begin
                if (complete) begin
                    acc_q <= '0;
                    win_q <= '0;
                end else begin
                    acc_q <= sum_d;
                    win_q <= win_q + 1'b1;
                end
            end

            if (reject && reject_cnt_q != 8'hFF) begin
                reject_cnt_q <= reject_cnt_q + 1'b1;
            end

            if (complete) begin
                avg_valid_q  <= 1'b1;
                avg_half_q   <= half_d;
                avg_period_q <= period_d;
                prev_q       <= half_d;
                prev_vld_q   <= 1'b1;
                match_q      <= match_d;
                locked_q     <= (match_d == MW'(LOCK_CNT));
                if (avg_valid_q && !bus.avg_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (avg_valid_q && bus.avg_ready) begin
                avg_valid_q <= 1'b0;
            end
        end
    end

    assign bus.avg_valid  = avg_valid_q;
    assign bus.avg_half   = avg_half_q;
    assign bus.avg_period = avg_period_q;
    assign bus.locked     = locked_q;
    assign bus.reject_cnt = reject_cnt_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_crossing_interval_averager.sv
// Directed bench: stimulus pushes expected averages, a monitor pops them on
// every accepted result and compares.
module tb_crossing_interval_averager;
    logic clk;
    logic reset;

    crossing_interval_averager_if #(.DW(8)) bus ();

    crossing_interval_averager #(
        .DW(8), .LOG2_N(2), .MIN_D(2), .MAX_D(250), .LOCK_TOL(2), .LOCK_CNT(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [7:0] half;
        logic [8:0] period;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: one scoreboard pop per transfer, sampled after the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.avg_valid === 1'b1 && bus.avg_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn half=%0d period=%0d locked=%0d (expect %0d/%0d/%0d)",
                             bus.avg_half, bus.avg_period, bus.locked,
                             e.half, e.period, e.locked);
                    check("avg_half",   32'(bus.avg_half),   32'(e.half));
                    check("avg_period", 32'(bus.avg_period), 32'(e.period));
                    check("locked",     32'(bus.locked),     32'(e.locked));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Strobe for one cycle, check avg_valid the next negedge, then idle.
    task automatic pulse(input logic [7:0] d, input logic exp_v);
        @(negedge clk);
        bus.s_pulse = 1'b1;
        bus.d_count = d;
        @(negedge clk);
        bus.s_pulse = 1'b0;
        check("avg_valid_after_pulse", 32'(bus.avg_valid), 32'(exp_v));
        repeat (8) @(negedge clk);
    endtask

    task automatic window(input logic [7:0] d, input logic [7:0] h,
                          input logic [8:0] p, input logic lk);
        exp_q.push_back('{half: h, period: p, locked: lk});
        for (int i = 0; i < 4; i++) pulse(d, i == 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        $display("reset-state check %s", tag);
        check("rst_valid",   32'(bus.avg_valid),  0);
        check("rst_half",    32'(bus.avg_half),   0);
        check("rst_period",  32'(bus.avg_period), 0);
        check("rst_locked",  32'(bus.locked),     0);
        check("rst_reject",  32'(bus.reject_cnt), 0);
        check("rst_overrun", 32'(bus.overrun),    0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.s_pulse   = 1'b0;
        bus.d_count   = '0;
        bus.avg_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("power_on");
        reset = 1'b0;

        // Constant interval 10
        pulse(8'd10, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b0);
        check("t1_reject", 32'(bus.reject_cnt), 0);

        // Jittered window, sum 42
        do_reset();
        pulse(8'd10, 1'b0);
        exp_q.push_back('{half: 8'd10, period: 9'd21, locked: 1'b0});
        pulse(8'd10, 1'b0);
        pulse(8'd11, 1'b0);
        pulse(8'd10, 1'b0);
        pulse(8'd11, 1'b1);

        // Rejection of 1 and 255
        do_reset();
        pulse(8'd10, 1'b0);
        exp_q.push_back('{half: 8'd10, period: 9'd20, locked: 1'b0});
        pulse(8'd10, 1'b0);
        pulse(8'd1, 1'b0);
        pulse(8'd255, 1'b0);
        pulse(8'd10, 1'b0);
        pulse(8'd10, 1'b0);
        pulse(8'd10, 1'b1);
        check("t3_reject", 32'(bus.reject_cnt), 2);

        // Lock acquisition and loss
        do_reset();
        pulse(8'd10, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b1);
        window(8'd20, 8'd20, 9'd40, 1'b0);

        // Overrun with ready held low
        do_reset();
        bus.avg_ready = 1'b0;
        pulse(8'd10, 1'b0);
        for (int i = 0; i < 4; i++) pulse(8'd10, i == 3);
        check("t5_no_overrun_yet", 32'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) pulse(8'd12, 1'b1);
        check("t5_overrun",  32'(bus.overrun),    1);
        check("t5_half",     32'(bus.avg_half),   12);
        check("t5_period",   32'(bus.avg_period), 24);
        exp_q.push_back('{half: 8'd12, period: 9'd24, locked: 1'b0});
        @(negedge clk);
        bus.avg_ready = 1'b1;
        @(negedge clk);
        bus.avg_ready = 1'b0;
        check("t5_valid_after_accept", 32'(bus.avg_valid), 0);
        check("t5_overrun_sticky",     32'(bus.overrun),   1);
        bus.avg_ready = 1'b1;

        // Asynchronous reset mid-window
        pulse(8'd10, 1'b0);
        pulse(8'd1, 1'b0);
        pulse(8'd10, 1'b0);
        check("t6_reject_pre", 32'(bus.reject_cnt), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_mid_window");
        @(negedge clk);
        reset = 1'b0;
        pulse(8'd10, 1'b0);
        window(8'd10, 8'd10, 9'd20, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
